// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types and constants for the SHA-256 core arbiter
//
// Purpose: arbiter FSM state encoding, block/digest widths and default timeout.
// Ports: none (package).
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ARM,
    RUN,
    RESP
  } state_t;

  localparam int BLOCK_W         = 512;
  localparam int DIGEST_W        = 256;
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/sha256_core_arbiter_if.sv
// rtl/sha256_core_arbiter_if.sv - request/response channels of the SHA-256 core arbiter
//
// Purpose: bundles the per-requester request channel and the shared response channel.
// Signals:
//   req_valid/req_ready  per-requester handshake (req_ready is a one-cycle accept pulse)
//   req_msg              flattened padded blocks, requester i at [512*i +: 512]
//   rsp_valid/rsp_ready  response handshake
//   rsp_id/rsp_hash/rsp_err  response payload
// Modports: slave (arbiter side), master (requester / consumer side).
interface sha256_core_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  import sha256_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*BLOCK_W-1:0] req_msg;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_W-1:0]            rsp_id;
  logic [DIGEST_W-1:0]        rsp_hash;
  logic                       rsp_err;

  modport slave (
    input  req_valid, req_msg, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_hash, rsp_err
  );

  modport master (
    output req_valid, req_msg, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_hash, rsp_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: picks the first set request searching upward from ptr+1 with wrap.
// Ports:
//   req    in  NUM_REQ  request vector
//   ptr    in  ID_W     index of the most recent grant
//   grant  out NUM_REQ  one-hot grant (zero when no request)
//   idx    out ID_W     index of the granted request
//   any    out 1        at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    // Distance 1 is checked first so the last winner has the lowest priority.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha256_core_arbiter.sv
// rtl/sha256_core_arbiter.sv - shares one SHA-256 core between NUM_REQ requesters
//
// Purpose: round-robin grant, message latch, core start sequencing, completion
// wait with timeout and an id-tagged response.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   bus           request/response channels (sha256_core_arbiter_if.slave)
//   core_message  latched 512-bit block to the core
//   core_reset    core reset, released only in ARM and RUN (acts as start)
//   core_ready    core done flag
//   core_hash     core digest
module sha256_core_arbiter
  import sha256_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  sha256_core_arbiter_if.slave bus,
  output logic [BLOCK_W-1:0]   core_message,
  output logic                 core_reset,
  input  logic                 core_ready,
  input  logic [DIGEST_W-1:0]  core_hash
);

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [7:0]         start_cnt;
  logic [7:0]         tmo_cnt;
  logic               timed_out;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // The accept pulse is only offered in IDLE, so it lasts exactly the grant cycle.
  assign bus.req_ready = (state == IDLE && !reset) ? gnt : '0;

  // tmo_cnt holds the number of ARM/RUN cycles already spent before this one.
  assign timed_out = (tmo_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= ID_W'(NUM_REQ - 1);
      start_cnt     <= '0;
      tmo_cnt       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_hash  <= '0;
      bus.rsp_err   <= 1'b0;
      core_message  <= '0;
      core_reset    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            core_message <= bus.req_msg[gnt_idx*BLOCK_W +: BLOCK_W];
            bus.rsp_id   <= gnt_idx;
            rr_ptr       <= gnt_idx;
            start_cnt    <= 8'(START_CYCLES - 1);
            state        <= START;
          end
        end
        START: begin
          if (start_cnt == 8'd0) begin
            tmo_cnt    <= '0;
            core_reset <= 1'b0;
            state      <= ARM;
          end else begin
            start_cnt <= start_cnt - 8'd1;
          end
        end
        ARM, RUN: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (state == RUN && core_ready) begin
            bus.rsp_hash  <= core_hash;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            core_reset    <= 1'b1;
            state         <= RESP;
          end else if (timed_out) begin
            bus.rsp_hash  <= '0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            core_reset    <= 1'b1;
            state         <= RESP;
          end else if (state == ARM && !core_ready) begin
            // Ready left high by the previous job must be seen low first.
            state <= RUN;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// tb/tb_sha256_core_arbiter.sv - directed self-checking bench for sha256_core_arbiter
module tb_sha256_core_arbiter;
  import sha256_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 255;
  localparam int LAT = 30;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] MSG_A     = {16{32'hA5A50001}};
  localparam logic [511:0] MSG_B     = {8{64'h0123456789ABCDEF}};
  localparam logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cbb10ff61f20015ad;
  localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] core_message;
  logic         core_reset;
  logic         core_ready = 1'b0;
  logic [255:0] core_hash = '0;

  int   mode = 0;
  int   ccnt = 0;
  logic running = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   gcyc = 0;
  int   rcyc = 0;
  int   n = 0;
  logic [255:0] all_exp [4];

  sha256_core_arbiter_if #(.NUM_REQ(N), .ID_W(2)) bus ();

  sha256_core_arbiter #(
    .NUM_REQ(N), .ID_W(2), .START_CYCLES(2), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .core_message(core_message), .core_reset(core_reset),
    .core_ready(core_ready), .core_hash(core_hash)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Known digests for the two real test vectors; other blocks map to a simple fold.
  function automatic logic [255:0] digest_of(input logic [511:0] m);
    if (m == ABC_BLK) return ABC_D;
    if (m == EMPTY_BLK) return EMPTY_D;
    return m[511:256] + m[255:0];
  endfunction

  // Core stub: ready and hash stay stale while held in reset, drop when released,
  // rise after LAT cycles. mode 1: ready stuck 0, mode 2: ready stuck 1.
  always @(posedge clk) begin
    if (mode == 1) begin
      core_ready <= 1'b0;
    end else if (mode == 2) begin
      core_ready <= 1'b1;
    end else if (core_reset) begin
      running <= 1'b0;
      ccnt    <= 0;
    end else if (!running) begin
      running    <= 1'b1;
      core_ready <= 1'b0;
      ccnt       <= 0;
    end else begin
      ccnt <= ccnt + 1;
      if (ccnt == LAT) begin
        core_ready <= 1'b1;
        core_hash  <= digest_of(core_message);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkh(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp);
    #1;
    for (int i = 0; i < 60 && bus.req_ready == 4'b0000; i++) begin
      @(negedge clk);
      #1;
    end
    gcyc = cyc;
    chk(tag, 32'(bus.req_ready), 32'(exp));
    @(negedge clk);
    bus.req_valid = bus.req_valid & ~exp;
    #1 chk({tag, "_pulse"}, 32'(bus.req_ready), 0);
  endtask

  task automatic wait_rsp(input string tag, input int id, input logic [255:0] h,
                          input int err, input int max);
    for (int i = 0; i < max && !bus.rsp_valid; i++) begin
      @(negedge clk);
      #1;
    end
    rcyc = cyc;
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 1);
    chk({tag, "_id"}, 32'(bus.rsp_id), id);
    chkh({tag, "_hash"}, bus.rsp_hash, h);
    chk({tag, "_err"}, 32'(bus.rsp_err), err);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1 chk({tag, "_done"}, 32'(bus.rsp_valid), 0);
  endtask

  task automatic measure_timeout(input string tag);
    for (int i = 0; i < 20 && core_reset; i++) begin
      @(negedge clk);
      #1;
    end
    n = 0;
    while (!bus.rsp_valid && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_cycles"}, 32'(n), TMO);
    chk({tag, "_core_reset"}, 32'(core_reset), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_msg   = '0;
    bus.rsp_ready = 1'b0;
    all_exp[0] = ABC_D;
    all_exp[1] = EMPTY_D;
    all_exp[2] = digest_of(MSG_A);
    all_exp[3] = digest_of(MSG_B);

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_core_reset", 32'(core_reset), 1);
    chkh("rst_rsp_hash", bus.rsp_hash, '0);
    chkh("rst_msg_hi", core_message[511:256], '0);
    chkh("rst_msg_lo", core_message[255:0], '0);
    @(negedge clk);
    reset = 1'b0;

    // "abc" from requester 0
    bus.req_msg[511:0] = ABC_BLK;
    bus.req_valid = 4'b0001;
    wait_grant("abc_grant", 4'b0001);
    wait_rsp("abc", 0, ABC_D, 0, 60);
    chk("abc_latency", 32'((rcyc - gcyc) <= 45), 1);

    // empty message from requester 3
    bus.req_msg[2047:1536] = EMPTY_BLK;
    bus.req_valid = 4'b1000;
    wait_grant("empty_grant", 4'b1000);
    chkh("empty_msg_hi", core_message[511:256], EMPTY_BLK[511:256]);
    chkh("empty_msg_lo", core_message[255:0], EMPTY_BLK[255:0]);
    wait_rsp("empty", 3, EMPTY_D, 0, 60);

    // all four from reset: grants 0,1,2,3
    reset = 1'b1;
    bus.req_msg = {MSG_B, MSG_A, EMPTY_BLK, ABC_BLK};
    bus.req_valid = 4'b1111;
    @(negedge clk);
    #1 chk("rst_gate_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_grant("all_grant", 4'(1 << k));
      wait_rsp("all_rsp", k, all_exp[k], 0, 60);
    end
    bus.req_valid = 4'b0011;
    wait_grant("wrap_grant0", 4'b0001);
    wait_rsp("wrap_rsp0", 0, ABC_D, 0, 60);
    wait_grant("wrap_grant1", 4'b0010);
    wait_rsp("wrap_rsp1", 1, EMPTY_D, 0, 60);

    // backpressure with requester 2 pending
    bus.req_valid = 4'b0001;
    wait_grant("bp_grant0", 4'b0001);
    for (int i = 0; i < 60 && !bus.rsp_valid; i++) begin
      @(negedge clk);
      #1;
    end
    bus.req_valid = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_id", 32'(bus.rsp_id), 0);
      chk("bp_err", 32'(bus.rsp_err), 0);
      chkh("bp_hash", bus.rsp_hash, ABC_D);
      chk("bp_no_ready", 32'(bus.req_ready), 0);
      chk("bp_core_reset", 32'(core_reset), 1);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    chk("bp_released", 32'(bus.rsp_valid), 0);
    chk("bp_regrant", 32'(bus.req_ready), 32'(4'b0100));
    wait_grant("bp_grant2", 4'b0100);
    wait_rsp("bp_rsp2", 2, all_exp[2], 0, 60);

    // timeout with ready stuck low, then stuck high
    mode = 1;
    bus.req_valid = 4'b0001;
    wait_grant("to0_grant", 4'b0001);
    measure_timeout("to0");
    wait_rsp("to0_rsp", 0, '0, 1, 5);
    mode = 2;
    bus.req_valid = 4'b0010;
    wait_grant("to1_grant", 4'b0010);
    measure_timeout("to1");
    wait_rsp("to1_rsp", 1, '0, 1, 5);

    // reset in the middle of RUN, then a fresh "abc" from requester 1
    mode = 0;
    bus.req_valid = 4'b0100;
    wait_grant("mid_grant", 4'b0100);
    for (int i = 0; i < 20 && core_reset; i++) begin
      @(negedge clk);
      #1;
    end
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("mid_core_reset", 32'(core_reset), 1);
    bus.req_msg[1023:512] = ABC_BLK;
    bus.req_valid = 4'b0010;
    wait_grant("mid_new_grant", 4'b0010);
    wait_rsp("mid_new_rsp", 1, ABC_D, 0, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
